timer0_peripheral: RTL and testbench
====================================

// Module: timer0_peripheral
// PURPOSE
//  TMR0/OPTION_REG peripheral on the external-peripheral side of the register file.
//  Responds when the register file does not claim an address (periph_en high).
//  Supplies read data for its registers, takes writes, counts, and raises the INTCON T0IF set strobe.
//  Clock source is the instruction-cycle tick or the T0CKI pin, with an optional 8-bit prescaler.
// PARAMETERS
//  SYNC_STAGES   2      T0CKI synchroniser depth (>=2).
//  INHIBIT_TICKS 2      inc_tick pulses for which TMR0 is frozen after a TMR0 write.
// PORTS
//  clk            in   1  system clock; single clock domain.
//  rst            in   1  reset, synchronous, active-high.
//  inc_tick       in   1  one-clk strobe per instruction cycle (Fosc/4) from the core.
//  t0cki          in   1  asynchronous external count pin.
//  addr           in   9  registered bank-qualified file address (same stage the regfile decodes).
//  periph_en      in   1  regfile did not claim addr; this block may respond.
//  wr_en          in   1  write strobe for addr; commits on clk edge.
//  data_in        in   8  write data.
//  data_out       out  8  read data; 8'h00 when hit=0.
//  hit            out  1  addr is TMR0 or OPTION_REG and periph_en=1.
//  t0if_set       out  1  one-clk pulse on TMR0 overflow 8'hFF->8'h00.
//  option_reg_val out  8  current OPTION_REG (RBPU, INTEDG consumed elsewhere).
// BEHAVIOUR
//  Decode: TMR0 @ 9'h001/9'h101; OPTION_REG @ 9'h081/9'h181. data_out, hit are combinational on addr/periph_en.
//  Reset (rst=1 at edge): TMR0=8'h00, OPTION_REG=8'hFF, prescaler=0, inhibit=0, sync/edge flops=0, t0if_set=0.
//  OPTION bits: [5]T0CS 0=inc_tick 1=T0CKI; [4]T0SE 0=rising 1=falling; [3]PSA 1=prescaler bypassed (1:1);
//   [2:0]PS, ratio 1:2^(PS+1) when PSA=0.
//  T0CKI path: SYNC_STAGES flops then one edge flop; src_tick = selected edge, one clk wide; latency SYNC_STAGES+1 clks.
//  src_tick = T0CS ? t0cki_edge : inc_tick.
//  Prescaler: 8-bit up counter advanced by src_tick. With PSA=0, cnt_tick fires when (cnt & mask)==mask and src_tick.
//   mask = 2^(PS+1)-1, so counter wraps naturally. With PSA=1, cnt_tick=src_tick.
//  Count: on cnt_tick with inhibit==0, TMR0<=TMR0+1 (mod 256); if TMR0 was 8'hFF, t0if_set=1 next clk (registered).
//  TMR0 write (hit&wr_en): TMR0<=data_in, prescaler<=0, inhibit<=INHIBIT_TICKS.
//   Write wins over a same-cycle cnt_tick: no increment, no t0if_set.
//  inhibit decrements on each inc_tick while nonzero, in both T0CS modes. Freeze is measured in instruction cycles.
//  OPTION write: OPTION<=data_in; prescaler<=0 if PSA or PS changes; TMR0 unchanged.
//   New T0CS/T0SE take effect the next clk; edge flop is not reset, so a mode switch may yield one spurious edge (accepted).
//  Writes with periph_en=0 or unmatched addr: ignored. Reads have no side effects.
//  Reset mid-count or mid-inhibit: everything returns to reset values; no t0if_set after rst.
//  Simultaneous overflow and OPTION write: overflow completes, t0if_set pulses.
// STRUCTURE
//  memory_map.vh gains tmr0_address, option_reg_address (casez patterns with bank bit 8 as don't-care).
//  It also gains OPTION bit-index localparams (T0CS_BIT, T0SE_BIT, PSA_BIT, PS_MSB/PS_LSB).
//  Sub-module t0_prescaler: src_tick, clr, psa, ps -> cnt_tick. Synchroniser and edge detect stay inline.
// TESTING
//  1 Reset, read 9'h081 -> 8'hFF; read 9'h001 -> 8'h00; hit=1 both; periph_en=0 -> hit=0, data_out=8'h00.
//  2 OPTION=8'h08 (1:1), TMR0=8'hFD, 6 inc_ticks -> ticks 1-2 frozen, then FE, FF, 00 (t0if_set 1 clk), 01.
//  3 OPTION=8'h02 (1:8), TMR0=8'h00, 2 inhibit ticks + 24 inc_ticks -> TMR0=8'h03; PS write mid-run clears prescaler.
//  4 OPTION=8'h28 (T0CKI rising), 5 pin pulses of 4 clks -> TMR0 +5, each step SYNC_STAGES+1 clks after edge.
//   OPTION=8'h38 -> counts on falling edges.
//  5 TMR0=8'hFF; write TMR0=8'h10 on the same clk as cnt_tick -> TMR0=8'h10, no t0if_set.
//  6 rst at 1 clk while inhibit=1 and prescaler=5 -> all reset values next clk; counting resumes without the freeze.

Source files
------------

// File: rtl/timer0_peripheral_pkg.sv
// Shared decode, OPTION_REG field positions and prescaler helpers for the TMR0 peripheral.
package timer0_peripheral_pkg;

  localparam int unsigned T0CS_BIT = 5;
  localparam int unsigned T0SE_BIT = 4;
  localparam int unsigned PSA_BIT  = 3;
  localparam int unsigned PS_MSB   = 2;
  localparam int unsigned PS_LSB   = 0;

  localparam logic [7:0] OPTION_RESET = 8'hFF;
  localparam logic [7:0] TMR0_RESET   = 8'h00;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_TMR0,
    SEL_OPTION
  } reg_sel_e;

  // Bank bit 8 is a don't-care: TMR0 at 0x001/0x101, OPTION_REG at 0x081/0x181.
  function automatic reg_sel_e decode_reg(input logic [8:0] a);
    reg_sel_e s;
    casez (a)
      9'b?_0000_0001: s = SEL_TMR0;
      9'b?_1000_0001: s = SEL_OPTION;
      default:        s = SEL_NONE;
    endcase
    return s;
  endfunction

  function automatic logic [7:0] prescale_mask(input logic [2:0] ps);
    logic [8:0] span;
    span = 9'd1 << ({1'b0, ps} + 4'd1);
    return 8'(span - 9'd1);
  endfunction

endpackage

// File: rtl/timer0_peripheral_t0_prescaler.sv
// Free-running 8-bit prescaler; emits cnt_tick once every 2^(ps+1) source ticks unless bypassed.
module t0_prescaler
  import timer0_peripheral_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       src_tick,
  input  logic       clr,
  input  logic       psa,
  input  logic [2:0] ps,
  output logic       cnt_tick
);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;
  logic [7:0] mask;

  always_comb begin
    mask  = prescale_mask(ps);
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (src_tick) begin
      cnt_d = cnt_q + 8'd1;
    end
    cnt_tick = src_tick & (psa | ((cnt_q & mask) == mask));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/timer0_peripheral.sv
// TMR0 / OPTION_REG peripheral: register access, clock-source selection, prescaling,
// post-write count inhibit and the T0IF set strobe.
module timer0_peripheral
  import timer0_peripheral_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned INHIBIT_TICKS = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc_tick,
  input  logic       t0cki,
  input  logic [8:0] addr,
  input  logic       periph_en,
  input  logic       wr_en,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       hit,
  output logic       t0if_set,
  output logic [7:0] option_reg_val
);

  localparam int unsigned INH_W = (INHIBIT_TICKS < 1) ? 1 : $clog2(INHIBIT_TICKS + 1);
  localparam logic [INH_W-1:0] INH_LOAD = INH_W'(INHIBIT_TICKS);

  logic [7:0]             tmr0_q, tmr0_d;
  logic [7:0]             option_q, option_d;
  logic [INH_W-1:0]       inhibit_q, inhibit_d;
  logic                   t0if_q, t0if_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   edge_q;

  reg_sel_e sel;
  logic     tmr0_wr;
  logic     option_wr;
  logic     pin_rise;
  logic     pin_fall;
  logic     t0cki_edge;
  logic     src_tick;
  logic     pre_clr;
  logic     cnt_tick;
  logic     count_en;

  always_comb begin
    sel = SEL_NONE;
    if (periph_en) begin
      sel = decode_reg(addr);
    end
    hit = (sel != SEL_NONE);
    case (sel)
      SEL_TMR0:   data_out = tmr0_q;
      SEL_OPTION: data_out = option_q;
      default:    data_out = 8'h00;
    endcase
  end

  assign tmr0_wr   = wr_en & (sel == SEL_TMR0);
  assign option_wr = wr_en & (sel == SEL_OPTION);

  // Edge flop trails the last sync stage; the edge is seen SYNC_STAGES+1 clks after the pin moves.
  assign pin_rise   =  sync_q[SYNC_STAGES-1] & ~edge_q;
  assign pin_fall   = ~sync_q[SYNC_STAGES-1] &  edge_q;
  assign t0cki_edge = option_q[T0SE_BIT] ? pin_fall : pin_rise;
  assign src_tick   = option_q[T0CS_BIT] ? t0cki_edge : inc_tick;

  assign pre_clr = tmr0_wr
                 | (option_wr & ((data_in[PSA_BIT] != option_q[PSA_BIT])
                              || (data_in[PS_MSB:PS_LSB] != option_q[PS_MSB:PS_LSB])));

  t0_prescaler u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .src_tick (src_tick),
    .clr      (pre_clr),
    .psa      (option_q[PSA_BIT]),
    .ps       (option_q[PS_MSB:PS_LSB]),
    .cnt_tick (cnt_tick)
  );

  // A TMR0 write takes priority over a coincident count, suppressing both increment and T0IF.
  assign count_en = cnt_tick & (inhibit_q == '0) & ~tmr0_wr;

  always_comb begin
    tmr0_d    = tmr0_q;
    option_d  = option_q;
    inhibit_d = inhibit_q;
    t0if_d    = count_en & (tmr0_q == 8'hFF);

    if (tmr0_wr) begin
      tmr0_d = data_in;
    end else if (count_en) begin
      tmr0_d = tmr0_q + 8'd1;
    end

    if (option_wr) begin
      option_d = data_in;
    end

    if (tmr0_wr) begin
      inhibit_d = INH_LOAD;
    end else if (inc_tick && (inhibit_q != '0)) begin
      inhibit_d = inhibit_q - INH_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tmr0_q    <= TMR0_RESET;
      option_q  <= OPTION_RESET;
      inhibit_q <= '0;
      t0if_q    <= 1'b0;
      sync_q    <= '0;
      edge_q    <= 1'b0;
    end else begin
      tmr0_q    <= tmr0_d;
      option_q  <= option_d;
      inhibit_q <= inhibit_d;
      t0if_q    <= t0if_d;
      sync_q    <= {sync_q[SYNC_STAGES-2:0], t0cki};
      edge_q    <= sync_q[SYNC_STAGES-1];
    end
  end

  assign t0if_set       = t0if_q;
  assign option_reg_val = option_q;

endmodule

// File: tb/tb_timer0_peripheral.sv
// Self-checking bench for timer0_peripheral: behavioural model plus directed and random stimulus.
`timescale 1ns/1ps
module tb_timer0_peripheral;

  localparam int unsigned S   = 2;
  localparam int unsigned INH = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       inc_tick;
  logic       t0cki;
  logic [8:0] addr;
  logic       periph_en;
  logic       wr_en;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       hit;
  logic       t0if_set;
  logic [7:0] option_reg_val;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  timer0_peripheral #(
    .SYNC_STAGES   (S),
    .INHIBIT_TICKS (INH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .inc_tick       (inc_tick),
    .t0cki          (t0cki),
    .addr           (addr),
    .periph_en      (periph_en),
    .wr_en          (wr_en),
    .data_in        (data_in),
    .data_out       (data_out),
    .hit            (hit),
    .t0if_set       (t0if_set),
    .option_reg_val (option_reg_val)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int        m_tmr;
  int        m_pre;
  int        m_inh;
  logic [7:0] m_opt;
  bit        m_t0if;
  bit        m_valid = 1'b0;
  bit        m_hist[$];   // pin samples per clk edge, oldest first

  function automatic int sel_of(input logic pe, input logic [8:0] a);
    if (!pe) return 0;
    if (a[7:0] == 8'h01) return 1;
    if (a[7:0] == 8'h81) return 2;
    return 0;
  endfunction

  always @(posedge clk) begin : model
    int sel;
    int ratio;
    bit src;
    bit ctick;
    bit twr;
    bit owr;
    if (rst) begin
      m_tmr  = 0;
      m_opt  = 8'hFF;
      m_pre  = 0;
      m_inh  = 0;
      m_t0if = 1'b0;
      m_hist.delete();
      for (int i = 0; i < int'(S) + 1; i++) m_hist.push_back(1'b0);
      m_valid = 1'b1;
    end else if (m_valid) begin
      sel = sel_of(periph_en, addr);
      twr = wr_en && (sel == 1);
      owr = wr_en && (sel == 2);
      if (m_opt[5])
        src = m_opt[4] ? (m_hist[0] && !m_hist[1]) : (!m_hist[0] && m_hist[1]);
      else
        src = inc_tick;
      ratio = m_opt[3] ? 1 : (2 << m_opt[2:0]);
      ctick = src && ((m_pre % ratio) == ratio - 1);
      m_t0if = ctick && (m_inh == 0) && !twr && (m_tmr == 255);
      if (twr) m_tmr = int'(data_in);
      else if (ctick && m_inh == 0) m_tmr = (m_tmr + 1) % 256;
      if (twr || (owr && (data_in[3] != m_opt[3] || data_in[2:0] != m_opt[2:0]))) m_pre = 0;
      else if (src) m_pre = (m_pre + 1) % 256;
      if (twr) m_inh = int'(INH);
      else if (inc_tick && m_inh > 0) m_inh = m_inh - 1;
      if (owr) m_opt = data_in;
      void'(m_hist.pop_front());
      m_hist.push_back(t0cki);
    end
  end

  // Single compare process: all outputs against the model, every cycle.
  always @(negedge clk) begin : compare
    int sel;
    logic [7:0] exp_do;
    if (m_valid) begin
      sel = sel_of(periph_en, addr);
      exp_do = (sel == 1) ? 8'(m_tmr) : (sel == 2) ? m_opt : 8'h00;
      check("hit", {31'd0, hit}, {31'd0, (sel != 0)});
      check("data_out", {24'd0, data_out}, {24'd0, exp_do});
      check("t0if_set", {31'd0, t0if_set}, {31'd0, m_t0if});
      check("option_reg_val", {24'd0, option_reg_val}, {24'd0, m_opt});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input logic pe, input logic [8:0] a, input logic we,
                     input logic [7:0] d, input logic inc, input logic pin);
    @(negedge clk);
    #2;
    rst = 1'b0; periph_en = pe; addr = a; wr_en = we; data_in = d; inc_tick = inc; t0cki = pin;
  endtask

  task automatic rst_cyc();
    @(negedge clk);
    #2;
    rst = 1'b1; periph_en = 1'b0; addr = 9'h000; wr_en = 1'b0; data_in = 8'h00;
    inc_tick = 1'b0; t0cki = 1'b0;
  endtask

  task automatic wr(input logic [8:0] a, input logic [7:0] d);
    cyc(1'b1, a, 1'b1, d, 1'b0, 1'b0);
  endtask

  task automatic tick();
    cyc(1'b1, 9'h001, 1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic pin_cyc(input logic pin);
    cyc(1'b1, 9'h001, 1'b0, 8'h00, 1'b0, pin);
  endtask

  task automatic rd(input logic [8:0] a, output logic [7:0] v);
    cyc(1'b1, a, 1'b0, 8'h00, 1'b0, 1'b0);
    #1;
    v = data_out;
  endtask

  logic [7:0] v;
  logic [7:0] e2 [6];
  logic [8:0] ra;
  logic       rpin;

  initial begin
    rst = 1'b1; periph_en = 1'b0; addr = 9'h000; wr_en = 1'b0; data_in = 8'h00;
    inc_tick = 1'b0; t0cki = 1'b0;
    rst_cyc();
    rst_cyc();

    // 1: reset values and decode
    rd(9'h081, v); check("t1_option", {24'd0, v}, 32'hFF); check("t1_hit_opt", {31'd0, hit}, 32'd1);
    rd(9'h181, v); check("t1_option_b1", {24'd0, v}, 32'hFF);
    rd(9'h001, v); check("t1_tmr0", {24'd0, v}, 32'h00); check("t1_hit_tmr", {31'd0, hit}, 32'd1);
    rd(9'h101, v); check("t1_tmr0_b1", {24'd0, v}, 32'h00);
    cyc(1'b0, 9'h081, 1'b0, 8'h00, 1'b0, 1'b0); #1;
    check("t1_nohit", {31'd0, hit}, 32'd0); check("t1_nodata", {24'd0, data_out}, 32'h00);
    cyc(1'b0, 9'h081, 1'b1, 8'h00, 1'b0, 1'b0);
    rd(9'h081, v); check("t1_ignored_wr", {24'd0, v}, 32'hFF);

    // 2: 1:1, inhibit then overflow
    wr(9'h081, 8'h08);
    wr(9'h001, 8'hFD);
    e2 = '{8'hFD, 8'hFD, 8'hFE, 8'hFF, 8'h00, 8'h01};
    for (int k = 0; k < 6; k++) begin
      tick();
      rd(9'h001, v);
      check($sformatf("t2_tmr0_%0d", k), {24'd0, v}, {24'd0, e2[k]});
      check($sformatf("t2_t0if_%0d", k), {31'd0, t0if_set}, (k == 4) ? 32'd1 : 32'd0);
    end
    check("t2_model_tmr", m_tmr, 32'h01);

    // 3: 1:8 prescaler, then PS change clears it
    wr(9'h081, 8'h02);
    wr(9'h001, 8'h00);
    repeat (26) tick();
    rd(9'h001, v); check("t3_tmr0", {24'd0, v}, 32'h03);
    check("t3_model_pre", m_pre, 32'd26);
    wr(9'h081, 8'h03);
    repeat (15) tick();
    rd(9'h001, v); check("t3_clr_15", {24'd0, v}, 32'h03);
    tick();
    rd(9'h001, v); check("t3_clr_16", {24'd0, v}, 32'h04);

    // 4: T0CKI rising edges, then falling edges
    wr(9'h081, 8'h28);
    wr(9'h001, 8'h40);
    repeat (2) tick();
    for (int i = 0; i < 5; i++) begin
      repeat (S + 1) pin_cyc(1'b1);
      #1; check($sformatf("t4_before_%0d", i), {24'd0, data_out}, 32'h40 + i);
      pin_cyc(1'b1);
      #1; check($sformatf("t4_after_%0d", i), {24'd0, data_out}, 32'h41 + i);
      repeat (4) pin_cyc(1'b0);
    end
    wr(9'h081, 8'h38);
    for (int i = 0; i < 3; i++) begin
      repeat (4) pin_cyc(1'b1);
      #1; check($sformatf("t4_fall_rise_%0d", i), {24'd0, data_out}, 32'h45 + i);
      repeat (4) pin_cyc(1'b0);
    end
    rd(9'h001, v); check("t4_fall_total", {24'd0, v}, 32'h48);

    // 5: write beats coincident count; OPTION write does not block overflow
    wr(9'h081, 8'h08);
    wr(9'h001, 8'hFF);
    repeat (2) tick();
    cyc(1'b1, 9'h001, 1'b1, 8'h10, 1'b1, 1'b0);
    rd(9'h001, v); check("t5_tmr0", {24'd0, v}, 32'h10);
    check("t5_t0if", {31'd0, t0if_set}, 32'd0);
    wr(9'h001, 8'hFF);
    repeat (2) tick();
    cyc(1'b1, 9'h081, 1'b1, 8'h08, 1'b1, 1'b0);
    rd(9'h001, v); check("t5_ovf_tmr0", {24'd0, v}, 32'h00);
    check("t5_ovf_t0if", {31'd0, t0if_set}, 32'd1);

    // 6: reset while inhibited with prescaler mid-count
    wr(9'h081, 8'h22);
    wr(9'h001, 8'h20);
    tick();
    repeat (5) begin
      repeat (4) pin_cyc(1'b1);
      repeat (4) pin_cyc(1'b0);
    end
    check("t6_model_pre", m_pre, 32'd5);
    check("t6_model_inh", m_inh, 32'd1);
    rst_cyc();
    rd(9'h081, v); check("t6_option", {24'd0, v}, 32'hFF);
    rd(9'h001, v); check("t6_tmr0", {24'd0, v}, 32'h00);
    check("t6_t0if", {31'd0, t0if_set}, 32'd0);
    wr(9'h081, 8'h08);
    tick();
    rd(9'h001, v); check("t6_resume", {24'd0, v}, 32'h01);

    // Random traffic against the model
    rpin = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        rst_cyc();
        rpin = 1'b0;
      end else begin
        case ($urandom_range(0, 4))
          0:       ra = 9'h001;
          1:       ra = 9'h101;
          2:       ra = 9'h081;
          3:       ra = 9'h181;
          default: ra = 9'($urandom);
        endcase
        if ($urandom_range(0, 3) == 0) rpin = ~rpin;
        cyc($urandom_range(0, 9) != 0, ra, $urandom_range(0, 19) == 0, 8'($urandom),
            $urandom_range(0, 3) == 0, rpin);
      end
    end
    cyc(1'b0, 9'h000, 1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
